// File: rtl/imem_loader_if.sv
// Bundle of the program-byte stream, instruction-memory write port and status
// lines of the loader. The slave view belongs to the loader; the master view to whoever drives it.
interface imem_loader_if;
    logic        start;
    logic [31:0] len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        cpu_stall;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  start, len, byte_valid, byte_data,
        output byte_ready, mem_we, mem_waddr, mem_wdata, mem_wstrb,
        output cpu_stall, busy, done, err
    );

    modport master (
        output start, len, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_waddr, mem_wdata, mem_wstrb,
        input  cpu_stall, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory as little-endian 32-bit words,
// holding the CPU stalled until a complete program has been written.
module imem_loader #(
    parameter int unsigned MEM_SIZE  = 4096,
    parameter logic [31:0] START_POS = 32'hBFC00000
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    // Counter must hold MEM_SIZE itself and expose a 2-bit lane index.
    localparam int CNT_W = ($clog2(MEM_SIZE + 1) < 2) ? 2 : $clog2(MEM_SIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic [31:0]      r_word;
    logic [3:0]       r_strb;

    logic             w_idle_like;
    logic             w_len_big;
    logic             w_len_zero;
    logic             w_accept;
    logic             w_word_full;
    logic             w_last;
    logic [1:0]       w_lane;
    logic [CNT_W-1:0] w_n;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    assign w_len_big   = (bus.len > 32'(MEM_SIZE));
    assign w_len_zero  = (bus.len == 32'd0);
    assign w_accept    = (r_state == S_LOAD) && bus.byte_valid;
    assign w_lane      = r_cnt[1:0];
    assign w_word_full = (w_lane == 2'd3);
    assign w_last      = (r_cnt == (r_len - CNT_W'(1)));
    // In WRITE the counter is one past the last accepted byte.
    assign w_n         = r_cnt - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_waddr  = 32'd0;
        bus.mem_wdata  = 32'd0;
        bus.mem_wstrb  = 4'd0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.err        = 1'b0;
        bus.cpu_stall  = 1'b1;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                bus.done      = (r_state == S_DONE);
                bus.err       = (r_state == S_ERROR);
                bus.cpu_stall = (r_state != S_DONE);
                if (bus.start) begin
                    if (w_len_big) begin
                        w_next = S_ERROR;
                    end else if (w_len_zero) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                bus.byte_ready = 1'b1;
                bus.busy       = 1'b1;
                if (w_accept && (w_word_full || w_last)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.busy      = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_waddr = START_POS + (32'(w_n) & ~32'd3);
                bus.mem_wdata = r_word;
                bus.mem_wstrb = r_strb;
                w_next        = (r_cnt == r_len) ? S_DONE : S_LOAD;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_word <= '0;
            r_strb <= '0;
        end else begin
            if (w_idle_like && bus.start && !w_len_big && !w_len_zero) begin
                r_cnt  <= '0;
                r_len  <= bus.len[CNT_W-1:0];
                r_word <= '0;
                r_strb <= '0;
            end else if (w_accept) begin
                r_word[8*w_lane +: 8] <= bus.byte_data;
                r_strb[w_lane]        <= 1'b1;
                r_cnt                 <= r_cnt + CNT_W'(1);
            end else if (r_state == S_WRITE) begin
                r_word <= '0;
                r_strb <= '0;
            end
        end
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_SIZE, default 4096, instruction memory size in bytes.
REQ-002 Parameter START_POS, default 32'hBFC00000, absolute byte address of memory byte 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 len  input  32  number of program bytes to load; sampled when start is accepted.
REQ-007 byte_valid  input  1  byte_data holds a valid program byte.
REQ-008 byte_data  input  8  program byte, in ascending address order.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 mem_we  output  1  single-cycle word write strobe to instruction memory.
REQ-011 mem_waddr  output  32  absolute word-aligned write address; bits [1:0] always 0.
REQ-012 mem_wdata  output  32  write data, little-endian: lane k = bits [8k+7:8k] = byte at mem_waddr+k.
REQ-013 mem_wstrb  output  4  per-lane byte enables for the write.
REQ-014 cpu_stall  output  1  holds the CPU fetch/PC while memory contents are invalid.
REQ-015 busy  output  1  a load is in progress.
REQ-016 done  output  1  the last load completed successfully.
REQ-017 err  output  1  the last start request was rejected.

Function
REQ-018 The block SHALL use states IDLE, LOAD, WRITE, DONE and ERROR.
REQ-019 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both 1; byte_ready SHALL be 1 only in LOAD.
REQ-020 In IDLE, DONE or ERROR, start=1 with len > MEM_SIZE SHALL go to ERROR next cycle, with err=1 and no writes.
REQ-021 In IDLE, DONE or ERROR, start=1 with len = 0 SHALL go to DONE next cycle with no writes.
REQ-022 In IDLE, DONE or ERROR, start=1 with 1 <= len <= MEM_SIZE SHALL:
- go to LOAD next cycle;
- clear the byte counter, word assembly register, done and err.
REQ-023 start SHALL be ignored in LOAD and WRITE.
REQ-024 The n-th accepted byte (n from 0) SHALL be placed in lane n mod 4 of the assembly register and SHALL set that lane's strobe bit.
REQ-025 An accepted byte that fills lane 3, or is byte number len-1, SHALL move the FSM to WRITE next cycle.
REQ-026 In WRITE, for exactly one cycle, the block SHALL drive:
- mem_we=1;
- mem_waddr = START_POS + 4*floor(n/4), where n is the last accepted byte's number;
- mem_wdata = assembled word, with unfilled lanes 0;
- mem_wstrb = filled-lane mask.
REQ-027 After WRITE the FSM SHALL go to DONE if len bytes have been accepted, else to LOAD, with the assembly register and strobes cleared.
REQ-028 mem_we SHALL be 0 in every state except WRITE; mem_waddr, mem_wdata and mem_wstrb SHALL be 0 when mem_we=0.
REQ-029 Sustained byte throughput SHALL be 4 bytes per 5 cycles; gaps in byte_valid SHALL only stretch LOAD.
REQ-030 Output levels by state:
- busy = 1 in LOAD and WRITE, else 0;
- done = 1 only in DONE;
- err = 1 only in ERROR;
- cpu_stall = 0 only in DONE, else 1.
REQ-031 The byte counter SHALL be wide enough to hold MEM_SIZE without wrap; address arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-032 rst_n=0 SHALL immediately, regardless of clk, force:
- FSM = IDLE, counter = 0, assembly register and strobes = 0;
- byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_wstrb=0;
- cpu_stall=1, busy=0, done=0, err=0.
REQ-033 Reset asserted mid-load SHALL discard the partial word; no write SHALL occur for it after reset is released.

Verification
REQ-034 Reset: hold rst_n=0 with random inputs -> outputs as REQ-032 at all times, with no clk edge needed.
REQ-035 start, len=8, bytes 01..08 back-to-back -> exactly two writes:
- BFC00000 / 04030201 / strb F;
- BFC00004 / 08070605 / strb F;
- then done=1, cpu_stall=0, busy=0.
REQ-036 start, len=5, bytes AA BB CC DD EE with byte_valid gaps -> writes BFC00000/DDCCBBAA/F and BFC00004/000000EE/1, then done=1.
REQ-037 start, len=0 -> done=1 the next cycle, no mem_we; start, len=4097 -> err=1, cpu_stall=1, no mem_we.
REQ-038 start, len=8; rst_n low after 2 accepted bytes -> no mem_we ever; after release, state IDLE, cpu_stall=1.
REQ-039 From DONE, start, len=4 -> cpu_stall=1 and busy=1 the next cycle; start pulsed again during LOAD is ignored; a single write to BFC00000 follows.
